// File: rtl/cp_strobe_gen_if.sv
// Control/status bundle for cp_strobe_gen: run controls in, virtual clock level and cp strobes out.
// CP_EXT_EN adds the external-clock inputs ext_clk/ext_sel.
interface cp_strobe_gen_if #(
    parameter int unsigned DIV_W  = 8,
    parameter int unsigned TICK_W = 16
);
    logic              en;
    logic              resync;
    logic [DIV_W-1:0]  div;
    logic              clk_lvl;
    logic              cp_rise;
    logic              cp_fall;
    logic [TICK_W-1:0] tick_cnt;
`ifdef CP_EXT_EN
    logic              ext_clk;
    logic              ext_sel;
`endif

    modport master (
`ifdef CP_EXT_EN
        output ext_clk, ext_sel,
`endif
        output en, resync, div,
        input  clk_lvl, cp_rise, cp_fall, tick_cnt
    );

    modport slave (
`ifdef CP_EXT_EN
        input  ext_clk, ext_sel,
`endif
        input  en, resync, div,
        output clk_lvl, cp_rise, cp_fall, tick_cnt
    );
endinterface

// File: rtl/cp_strobe_gen.sv
// Virtual-clock generator: produces one-cycle cp_rise/cp_fall enables and the clock level in sys_clk domain.
// CP_EXT_EN adds a synchronised external clock source selectable with ext_sel.
module cp_strobe_gen #(
    parameter int unsigned DIV_W  = 8,
    parameter int unsigned TICK_W = 16
) (
    input  logic            sys_clk,
    input  logic            sys_rst,
    cp_strobe_gen_if.slave  bus
);

    logic [DIV_W-1:0]  cnt;
    logic [TICK_W-1:0] tick;
    logic              lvl;
    logic              rise;
    logic              fall;

    logic [DIV_W-1:0]  cnt_nxt;
    logic              lvl_nxt;
    logic              rise_nxt;
    logic              fall_nxt;

    // >= rather than == so a div lowered below the running count still toggles next edge
    always_comb begin
        cnt_nxt  = cnt;
        lvl_nxt  = lvl;
        rise_nxt = 1'b0;
        fall_nxt = 1'b0;
        if (bus.resync) begin
            cnt_nxt = '0;
            lvl_nxt = 1'b0;
        end else if (bus.en) begin
            if (cnt >= bus.div) begin
                cnt_nxt  = '0;
                lvl_nxt  = ~lvl;
                rise_nxt = ~lvl;
                fall_nxt = lvl;
            end else begin
                cnt_nxt = cnt + 1'b1;
            end
        end
    end

`ifdef CP_EXT_EN
    logic sync_meta;
    logic sync_q;
    logic sync_d;
    logic sel_q;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            sync_meta <= 1'b0;
            sync_q    <= 1'b0;
            sync_d    <= 1'b0;
            sel_q     <= 1'b0;
        end else begin
            sync_meta <= bus.ext_clk;
            sync_q    <= sync_meta;
            sync_d    <= sync_q;
            sel_q     <= bus.ext_sel;
        end
    end

    logic ext_rise;
    logic ext_fall;
    logic sel_switch;

    assign ext_rise   = sync_q & ~sync_d;
    assign ext_fall   = ~sync_q & sync_d;
    assign sel_switch = bus.ext_sel ^ sel_q;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            cnt  <= '0;
            lvl  <= 1'b0;
            rise <= 1'b0;
            fall <= 1'b0;
            tick <= '0;
        end else if (bus.ext_sel) begin
            if (bus.resync) begin
                cnt <= '0;
            end
            lvl  <= sync_q;
            rise <= bus.en & ~sel_switch & ext_rise;
            fall <= bus.en & ~sel_switch & ext_fall;
            if (bus.en && !sel_switch && ext_rise) begin
                tick <= tick + 1'b1;
            end
        end else begin
            // divider state still advances on the switch edge; only its strobe is masked
            cnt  <= cnt_nxt;
            lvl  <= lvl_nxt;
            rise <= rise_nxt & ~sel_switch;
            fall <= fall_nxt & ~sel_switch;
            if (rise_nxt && !sel_switch) begin
                tick <= tick + 1'b1;
            end
        end
    end
`else
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            cnt  <= '0;
            lvl  <= 1'b0;
            rise <= 1'b0;
            fall <= 1'b0;
            tick <= '0;
        end else begin
            cnt  <= cnt_nxt;
            lvl  <= lvl_nxt;
            rise <= rise_nxt;
            fall <= fall_nxt;
            if (rise_nxt) begin
                tick <= tick + 1'b1;
            end
        end
    end
`endif

    assign bus.clk_lvl  = lvl;
    assign bus.cp_rise  = rise;
    assign bus.cp_fall  = fall;
    assign bus.tick_cnt = tick;

endmodule

// File: tb/tb_cp_strobe_gen.sv
// Directed self-checking bench for cp_strobe_gen (default build, divider path).
module tb_cp_strobe_gen;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    int   compared = 0;
    int   mismatched = 0;

    cp_strobe_gen_if #(.DIV_W(8), .TICK_W(16)) bus ();

    cp_strobe_gen #(.DIV_W(8), .TICK_W(16)) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .bus     (bus)
    );

    always #5 sys_clk = ~sys_clk;

    // {clk_lvl, cp_rise, cp_fall}
    logic [2:0] obs;
    assign obs = {bus.clk_lvl, bus.cp_rise, bus.cp_fall};

    task automatic edge_step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic do_reset(input logic [7:0] d);
        bus.div    = d;
        bus.en     = 1'b1;
        bus.resync = 1'b0;
        sys_rst    = 1'b1;
        @(negedge sys_clk);
        @(negedge sys_clk);
        sys_rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(8'd0);
        compared++;
        if ({obs, bus.tick_cnt} !== 19'd0) begin
            $display("FAIL reset_state got=%b/%0d exp=000/0", obs, bus.tick_cnt);
            mismatched++;
        end
    endtask

    task automatic test_div0();
        logic [2:0] exp;
        do_reset(8'd0);
        for (int e = 1; e <= 8; e++) begin
            edge_step();
            exp = (e % 2 == 1) ? 3'b110 : 3'b001;
            compared++;
            if (obs !== exp) begin
                $display("FAIL div0_edge%0d got=%b exp=%b", e, obs, exp);
                mismatched++;
            end
        end
        compared++;
        if (bus.tick_cnt !== 16'd4) begin
            $display("FAIL div0_tick got=%0d exp=4", bus.tick_cnt);
            mismatched++;
        end
    endtask

    task automatic test_div3_period();
        logic [2:0] exp;
        do_reset(8'd3);
        for (int e = 1; e <= 16; e++) begin
            edge_step();
            exp = {(e % 8) >= 4, (e % 8) == 4, (e % 8) == 0};
            compared++;
            if (obs !== exp) begin
                $display("FAIL div3_edge%0d got=%b exp=%b", e, obs, exp);
                mismatched++;
            end
        end
    endtask

    task automatic test_enable_hold();
        do_reset(8'd3);
        for (int e = 1; e <= 6; e++) edge_step();
        compared++;
        if (obs !== 3'b100) begin
            $display("FAIL hold_pre got=%b exp=100", obs);
            mismatched++;
        end
        bus.en = 1'b0;
        for (int e = 1; e <= 5; e++) begin
            edge_step();
            compared++;
            if (obs !== 3'b100) begin
                $display("FAIL hold_frozen%0d got=%b exp=100", e, obs);
                mismatched++;
            end
        end
        bus.en = 1'b1;
        edge_step();
        compared++;
        if (obs !== 3'b100) begin
            $display("FAIL hold_resume1 got=%b exp=100", obs);
            mismatched++;
        end
        edge_step();
        compared++;
        if (obs !== 3'b001 || bus.tick_cnt !== 16'd1) begin
            $display("FAIL hold_resume2 got=%b/%0d exp=001/1", obs, bus.tick_cnt);
            mismatched++;
        end
    endtask

    task automatic test_div_drop();
        logic [2:0] exp;
        do_reset(8'd9);
        for (int e = 1; e <= 6; e++) edge_step();
        compared++;
        if (obs !== 3'b000) begin
            $display("FAIL drop_pre got=%b exp=000", obs);
            mismatched++;
        end
        bus.div = 8'd2;
        edge_step();
        compared++;
        if (obs !== 3'b110) begin
            $display("FAIL drop_toggle got=%b exp=110", obs);
            mismatched++;
        end
        for (int k = 1; k <= 9; k++) begin
            edge_step();
            case (k % 6)
                0:       exp = 3'b110;
                1, 2:    exp = 3'b100;
                3:       exp = 3'b001;
                default: exp = 3'b000;
            endcase
            compared++;
            if (obs !== exp) begin
                $display("FAIL drop_k%0d got=%b exp=%b", k, obs, exp);
                mismatched++;
            end
        end
    endtask

    task automatic test_resync_terminal();
        do_reset(8'd3);
        for (int e = 1; e <= 7; e++) edge_step();
        compared++;
        if (obs !== 3'b100) begin
            $display("FAIL resync_pre got=%b exp=100", obs);
            mismatched++;
        end
        bus.resync = 1'b1;
        edge_step();
        bus.resync = 1'b0;
        compared++;
        if (obs !== 3'b000) begin
            $display("FAIL resync_edge got=%b exp=000", obs);
            mismatched++;
        end
        for (int e = 1; e <= 3; e++) begin
            edge_step();
            compared++;
            if (obs !== 3'b000) begin
                $display("FAIL resync_wait%0d got=%b exp=000", e, obs);
                mismatched++;
            end
        end
        edge_step();
        compared++;
        if (obs !== 3'b110 || bus.tick_cnt !== 16'd2) begin
            $display("FAIL resync_rise got=%b/%0d exp=110/2", obs, bus.tick_cnt);
            mismatched++;
        end
    endtask

    task automatic test_async_reset();
        do_reset(8'd0);
        edge_step();
        compared++;
        if (obs !== 3'b110) begin
            $display("FAIL areset_pre got=%b exp=110", obs);
            mismatched++;
        end
        #3;
        sys_rst = 1'b1;
        #1;
        compared++;
        if ({obs, bus.tick_cnt} !== 19'd0) begin
            $display("FAIL areset_now got=%b/%0d exp=000/0", obs, bus.tick_cnt);
            mismatched++;
        end
        @(negedge sys_clk);
        sys_rst = 1'b0;
    endtask

    initial begin
        bus.en     = 1'b0;
        bus.resync = 1'b0;
        bus.div    = '0;
        test_reset();
        test_div0();
        test_div3_period();
        test_enable_hold();
        test_div_drop();
        test_resync_terminal();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
